// File: rtl/id_decode_stage.sv
// id_decode_stage: IF->ID pipeline stage feeding the immediate generator.
// Accepts {pc, inst} on a valid/ready handshake, decodes the immediate format,
// and presents the result downstream through a 2-entry skid buffer (main + skid).
// Optional feature macro: DEC_ILLEGAL_EN (enables illegal-encoding detection on out_illegal).
module id_decode_stage #(
    parameter int          PC_W     = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [3:0]      out_imm_sel,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;

    // Immediate format: [3]=unsigned, [2:0]=0 none,1 I,2 IS,3 S,4 B,5 U,6 J.
    // Unrecognised opcodes fall through to 0000.
    function automatic logic [3:0] decode_imm_sel(input logic [31:0] inst);
        logic [3:0] sel;
        sel = 4'b0000;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC:               sel = 4'b0101;
            OPC_JAL:                          sel = 4'b0110;
            OPC_JALR, OPC_LOAD, OPC_SYSTEM:   sel = 4'b0001;
            OPC_BRANCH:                       sel = 4'b0100;
            OPC_STORE:                        sel = 4'b0011;
            OPC_OPIMM: begin
                case (inst[14:12])
                    3'b001, 3'b101: sel = 4'b0010;   // shifts use shamt form
                    3'b011:         sel = 4'b1001;   // SLTIU compares unsigned
                    default:        sel = 4'b0001;
                endcase
            end
            default:                          sel = 4'b0000;
        endcase
        return sel;
    endfunction

`ifdef DEC_ILLEGAL_EN
    // Every recognised opcode ends in 2'b11, so an opcode match also covers inst[1:0].
    function automatic logic decode_illegal(input logic [31:0] inst);
        logic ill;
        ill = 1'b1;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_SYSTEM,
            OPC_BRANCH, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_MISC: ill = 1'b0;
            default: ill = 1'b1;
        endcase
        return ill;
    endfunction
`endif

    // Skid entry
    logic            skid_valid;
    logic [PC_W-1:0] skid_pc;
    logic [31:0]     skid_inst;
    logic [3:0]      skid_imm_sel;

    logic [3:0]      in_imm_sel;
    logic            acc;
    logic            adv;
    logic            skid_load;

`ifdef DEC_ILLEGAL_EN
    logic            in_illegal;
    logic            skid_illegal;
    logic            main_illegal;
    assign out_illegal = main_illegal;
`else
    assign out_illegal = 1'b0;
`endif

    // Decode the entry being loaded, plus handshake qualifiers
    always_comb begin
        in_imm_sel = decode_imm_sel(in_inst);
`ifdef DEC_ILLEGAL_EN
        in_illegal = decode_illegal(in_inst);
`endif
        acc       = in_valid & in_ready;
        adv       = ~out_valid | out_ready;
        skid_load = acc & (~adv | skid_valid);
    end

    // Ready depends only on registered state: stop accepting once the skid entry is occupied
    assign in_ready = ~skid_valid;

    // Register indices are fixed fields of the held instruction
    assign out_rd  = out_inst[11:7];
    assign out_rs1 = out_inst[19:15];
    assign out_rs2 = out_inst[24:20];

    // Main entry and both valid bits: reset/flush first, then advance/fill/stall
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            skid_valid  <= 1'b0;
            out_pc      <= '0;
            out_inst    <= NOP_INST;
            out_imm_sel <= 4'b0000;
`ifdef DEC_ILLEGAL_EN
            main_illegal <= 1'b0;
`endif
        end else if (flush) begin
            out_valid   <= 1'b0;
            skid_valid  <= 1'b0;
            out_inst    <= NOP_INST;
            out_imm_sel <= 4'b0000;
`ifdef DEC_ILLEGAL_EN
            main_illegal <= 1'b0;
`endif
        end else if (adv) begin
            if (skid_valid) begin
                out_valid   <= 1'b1;
                out_pc      <= skid_pc;
                out_inst    <= skid_inst;
                out_imm_sel <= skid_imm_sel;
`ifdef DEC_ILLEGAL_EN
                main_illegal <= skid_illegal;
`endif
                skid_valid  <= acc;
            end else if (acc) begin
                out_valid   <= 1'b1;
                out_pc      <= in_pc;
                out_inst    <= in_inst;
                out_imm_sel <= in_imm_sel;
`ifdef DEC_ILLEGAL_EN
                main_illegal <= in_illegal;
`endif
            end else begin
                out_valid   <= 1'b0;
            end
        end else if (acc) begin
            skid_valid  <= 1'b1;
        end
    end

    // Skid payload: captured whenever the incoming entry cannot go straight to main
    always_ff @(posedge clk) begin
        if (!flush && skid_load) begin
            skid_pc      <= in_pc;
            skid_inst    <= in_inst;
            skid_imm_sel <= in_imm_sel;
`ifdef DEC_ILLEGAL_EN
            skid_illegal <= in_illegal;
`endif
        end
    end

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed self-checking bench for id_decode_stage.
// Honours DEC_ILLEGAL_EN the same way the design does.
module tb_id_decode_stage;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [PC_W-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [3:0]      out_imm_sel;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic            out_illegal;

    int errors = 0;
    int checks = 0;

    id_decode_stage #(.PC_W(PC_W), .NOP_INST(32'h00000013)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_imm_sel(out_imm_sel), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_inst !== 32'h00000013) begin errors++; $display("FAIL reset_out_inst got=%h exp=00000013", out_inst); end
        checks++; if (out_imm_sel !== 4'b0000) begin errors++; $display("FAIL reset_imm_sel got=%b exp=0000", out_imm_sel); end
        checks++; if (out_pc !== '0 || out_rd !== 5'd0 || out_illegal !== 1'b0) begin
            errors++; $display("FAIL reset_misc got pc=%h rd=%0d ill=%b exp 0/0/0", out_pc, out_rd, out_illegal); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] insts [3] = '{32'h00500093, 32'h0000A0B7, 32'h00C0006F};
        logic [3:0]  sels  [3] = '{4'b0001, 4'b0101, 4'b0110};
        logic [4:0]  rds   [3] = '{5'd1, 5'd1, 5'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = insts[i]; in_pc = 32'h1000 + 4 * i;
            step();
            checks++; if (out_valid !== 1'b1 || out_inst !== insts[i] || out_pc !== 32'h1000 + 4 * i) begin
                errors++; $display("FAIL stream_%0d got v=%b inst=%h pc=%h exp v=1 inst=%h pc=%h",
                                   i, out_valid, out_inst, out_pc, insts[i], 32'h1000 + 4 * i); end
            checks++; if (out_imm_sel !== sels[i] || out_rd !== rds[i]) begin
                errors++; $display("FAIL stream_sel_%0d got sel=%b rd=%0d exp sel=%b rd=%0d",
                                   i, out_imm_sel, out_rd, sels[i], rds[i]); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_decode_formats();
        logic [31:0] insts [6] = '{32'h00209093, 32'h0030B093, 32'h00112023, 32'hFE000EE3,
                                    32'h00002083, 32'h002081B3};
        logic [3:0]  sels  [6] = '{4'b0010, 4'b1001, 4'b0011, 4'b0100, 4'b0001, 4'b0000};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_inst = insts[i]; in_pc = 32'h2000 + 4 * i;
            step();
            checks++; if (out_valid !== 1'b1 || out_imm_sel !== sels[i]) begin
                errors++; $display("FAIL decode_%0d inst=%h got v=%b sel=%b exp v=1 sel=%b",
                                   i, insts[i], out_valid, out_imm_sel, sels[i]); end
            if (i == 2) begin
                checks++; if (out_rs1 !== 5'd2 || out_rs2 !== 5'd1) begin
                    errors++; $display("FAIL decode_sw_regs got rs1=%0d rs2=%0d exp rs1=2 rs2=1", out_rs1, out_rs2); end
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h3000;
        step();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_inst !== 32'h00500093) begin
            errors++; $display("FAIL bp_first got v=%b rdy=%b inst=%h exp v=1 rdy=1 inst=00500093",
                               out_valid, in_ready, out_inst); end
        in_inst = 32'h0000A0B7; in_pc = 32'h3004;
        step();
        checks++; if (in_ready !== 1'b0 || out_inst !== 32'h00500093 || out_pc !== 32'h3000) begin
            errors++; $display("FAIL bp_second got rdy=%b inst=%h pc=%h exp rdy=0 inst=00500093 pc=3000",
                               in_ready, out_inst, out_pc); end
        in_inst = 32'h00C0006F; in_pc = 32'h3008;
        step();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'h00500093) begin
            errors++; $display("FAIL bp_hold got rdy=%b v=%b inst=%h exp rdy=0 v=1 inst=00500093",
                               in_ready, out_valid, out_inst); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_inst !== 32'h0000A0B7 || out_pc !== 32'h3004 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_drain1 got v=%b inst=%h pc=%h rdy=%b exp v=1 inst=0000a0b7 pc=3004 rdy=1",
                               out_valid, out_inst, out_pc, in_ready); end
        checks++; if (out_imm_sel !== 4'b0101) begin errors++; $display("FAIL bp_drain1_sel got=%b exp=0101", out_imm_sel); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain2 got v=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h4000;
        step();
        in_inst = 32'h0000A0B7; in_pc = 32'h4004;
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_setup_full got rdy=%b exp=0", in_ready); end
        flush = 1'b1; in_inst = 32'h00C0006F; in_pc = 32'h4008;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_inst !== 32'h00000013 || in_ready !== 1'b1 || out_imm_sel !== 4'b0000) begin
            errors++; $display("FAIL flush_clear got v=%b inst=%h rdy=%b sel=%b exp v=0 inst=00000013 rdy=1 sel=0000",
                               out_valid, out_inst, in_ready, out_imm_sel); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got v=%b inst=%h exp v=0", out_valid, out_inst); end
        in_valid = 1'b1; in_inst = 32'h00112023; in_pc = 32'h5000;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_inst !== 32'h00112023 || out_pc !== 32'h5000) begin
            errors++; $display("FAIL flush_resume got v=%b inst=%h pc=%h exp v=1 inst=00112023 pc=5000",
                               out_valid, out_inst, out_pc); end
        step();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00000000; in_pc = 32'h6000;
        step();
`ifdef DEC_ILLEGAL_EN
        checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL illegal_zero got=%b exp=1", out_illegal); end
`else
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL illegal_tied got=%b exp=0", out_illegal); end
`endif
        checks++; if (out_valid !== 1'b1 || out_imm_sel !== 4'b0000) begin
            errors++; $display("FAIL illegal_sel got v=%b sel=%b exp v=1 sel=0000", out_valid, out_imm_sel); end
        in_inst = 32'h0000A0B7;
        step();
        checks++; if (out_illegal !== 1'b0 || out_imm_sel !== 4'b0101) begin
            errors++; $display("FAIL illegal_legal_lui got ill=%b sel=%b exp ill=0 sel=0101", out_illegal, out_imm_sel); end
        in_inst = 32'h00500091;
        step();
`ifdef DEC_ILLEGAL_EN
        checks++; if (out_illegal !== 1'b1 || out_imm_sel !== 4'b0000) begin
            errors++; $display("FAIL illegal_low_bits got ill=%b sel=%b exp ill=1 sel=0000", out_illegal, out_imm_sel); end
`else
        checks++; if (out_illegal !== 1'b0 || out_imm_sel !== 4'b0000) begin
            errors++; $display("FAIL illegal_low_bits got ill=%b sel=%b exp ill=0 sel=0000", out_illegal, out_imm_sel); end
`endif
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_decode_formats();
        test_backpressure();
        test_flush();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
